// File: rtl/seq_det_pkg.sv
// Shared types and reset-time defaults for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HUNT = 1'b1
  } det_state_e;

  localparam int          RST_MAX_LEN = 8;
  localparam int          RST_CNT_W   = 8;
  localparam logic [15:0] RST_PATTERN = 16'h0005;
  localparam int          RST_LEN     = 4;
  localparam logic        RST_INV     = 1'b1;
  localparam logic        RST_OVL     = 1'b1;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked window compare against the pattern and against its bitwise inverse.
module seq_det_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_win,
  input  logic [W-1:0] i_pat,
  input  logic [W-1:0] i_mask,
  output logic         o_hit,
  output logic         o_hit_inv
);

  assign o_hit     = ((i_win ^ i_pat) & i_mask) == '0;
  assign o_hit_inv = ((i_win ^ ~i_pat) & i_mask) == '0;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy sequence detector with optional inverse match,
// overlap control and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = RST_MAX_LEN,
  parameter int                 CNT_W       = RST_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(RST_PATTERN),
  parameter int                 DEF_LEN     = RST_LEN,
  parameter logic               DEF_INV     = RST_INV,
  parameter logic               DEF_OVL     = RST_OVL,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               slowed_clk,
  input  logic               reset,
  input  logic               d_in,
  input  logic               d_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_inv,
  input  logic               cfg_ovl,
  output logic               detected,
  output logic               det_inv,
  output logic               detected_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [MAX_LEN:0] ONE = 1;

  // The oldest history bit never reaches a window of at most MAX_LEN bits,
  // so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] r_hist, w_hist_nxt;
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt, w_fill_sat;
  logic               r_inv, w_inv_nxt;
  logic               r_ovl, w_ovl_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_det_q, r_cfg_err;

  det_state_e         w_state;
  logic [LEN_W:0]     w_fill_inc;
  logic [MAX_LEN:0]   w_mask_ext;
  logic [MAX_LEN-1:0] w_win, w_mask;
  logic               w_hit, w_hit_inv, w_cfg_ok, w_cfg_take, w_cmp_en;
  logic               w_match_t, w_match_i, w_match;

  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  assign w_state    = (w_fill_inc >= {1'b0, r_len}) ? HUNT : FILL;
  assign w_fill_sat = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : w_fill_inc[LEN_W-1:0];

  assign w_win      = {r_hist, d_in};
  assign w_mask_ext = (ONE << r_len) - ONE;
  assign w_mask     = w_mask_ext[MAX_LEN-1:0];

  assign w_cfg_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_cfg_take = cfg_load && w_cfg_ok;

  seq_det_cmp #(.W(MAX_LEN)) u_cmp (
    .i_win     (w_win),
    .i_pat     (r_pat),
    .i_mask    (w_mask),
    .o_hit     (w_hit),
    .o_hit_inv (w_hit_inv)
  );

  // A valid config load swallows this cycle's bit, so no match can fire.
  assign w_cmp_en  = d_valid && (w_state == HUNT) && !reset && !w_cfg_take;
  assign w_match_t = w_cmp_en && w_hit;
  assign w_match_i = w_cmp_en && r_inv && w_hit_inv;
  assign w_match   = w_match_t || w_match_i;

  assign detected    = w_match;
  assign det_inv     = w_match_i && !w_match_t;
  assign detected_q  = r_det_q;
  assign match_count = r_cnt;
  assign cfg_err     = r_cfg_err;

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_inv_nxt  = r_inv;
    w_ovl_nxt  = r_ovl;
    w_cnt_nxt  = r_cnt;
    if (w_cfg_take) begin
      w_pat_nxt  = cfg_pattern;
      w_len_nxt  = cfg_len;
      w_inv_nxt  = cfg_inv;
      w_ovl_nxt  = cfg_ovl;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      w_cnt_nxt  = '0;
    end else if (d_valid) begin
      w_hist_nxt = w_win[MAX_LEN-2:0];
      w_fill_nxt = (w_match && !r_ovl) ? '0 : w_fill_sat;
      if (w_match && (r_cnt != '1)) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge slowed_clk) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_inv     <= DEF_INV;
      r_ovl     <= DEF_OVL;
      r_cnt     <= '0;
      r_det_q   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_inv     <= w_inv_nxt;
      r_ovl     <= w_ovl_nxt;
      r_cnt     <= w_cnt_nxt;
      r_det_q   <= w_match;
      r_cfg_err <= cfg_load && !w_cfg_ok;
    end
  end

endmodule
